// File: rtl/tqvp_spike_odom_encoder.sv
// Odometry spike-train transmitter on the TinyQV peripheral bus.
// The CPU queues {dir, count} move commands; the FSM plays them out as one-hot E/N/W/S spikes.
module tqvp_spike_odom_encoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt,
   output logic [1:0]  dbg_state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
   state_t state, state_nxt;

   logic [17:0]   cfg;
   logic [17:0]   fifo_mem [FIFO_DEPTH];
   logic [17:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic [2:0]    level3;
   logic          full, empty, busy, enable;
   logic          overflow, done_pend;
   logic [31:0]   total;
   logic [15:0]   remaining, remaining_nxt;
   logic [1:0]    cur_dir, cur_dir_nxt;
   logic [7:0]    cnt, cnt_nxt, hi_load, lo_load;
   logic          we_any, we_word, push_req, push_ok, pop, clear_wr;
   logic          total_inc, completed, done_set, overflow_set;
   logic          unused_inputs;

   assign we_any   = data_write_n != 2'b11;
   assign we_word  = data_write_n == 2'b10;
   assign clear_wr = we_any && (address == 6'h10);
   assign enable   = cfg[16];

   // FIFO handshake: push_req is the valid, (~full | pop) is the ready; a push completes
   // only when both are high. pop is asserted by the FSM only while IDLE, enabled and !empty.
   assign push_req     = we_word && (address == 6'h00);
   assign full         = level == LW'(FIFO_DEPTH);
   assign empty        = level == '0;
   assign push_ok      = push_req && (!full || pop);
   assign overflow_set = push_req && full && !pop;
   assign head         = fifo_mem[rd_ptr];
   assign level3       = 3'(level);

   // Phase counters count down to zero, so a width of N is loaded as N-1 (0 behaves as 1).
   assign hi_load = (cfg[7:0]  == 8'd0) ? 8'd0 : cfg[7:0]  - 8'd1;
   assign lo_load = (cfg[15:8] == 8'd0) ? 8'd0 : cfg[15:8] - 8'd1;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      remaining_nxt = remaining;
      cur_dir_nxt   = cur_dir;
      pop           = 1'b0;
      total_inc     = 1'b0;
      completed     = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && !empty) begin
               pop = 1'b1;
               if (head[15:0] == 16'd0) begin
                  completed = 1'b1;
               end else begin
                  cur_dir_nxt   = head[17:16];
                  remaining_nxt = head[15:0];
                  cnt_nxt       = hi_load;
                  state_nxt     = HIGH;
               end
            end
         end
         HIGH: begin
            if (!enable) begin
               remaining_nxt = 16'd0;
               state_nxt     = IDLE;
            end else if (cnt == 8'd0) begin
               remaining_nxt = remaining - 16'd1;
               total_inc     = 1'b1;
               cnt_nxt       = lo_load;
               state_nxt     = LOW;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         LOW: begin
            if (!enable) begin
               remaining_nxt = 16'd0;
               state_nxt     = IDLE;
            end else if (cnt == 8'd0) begin
               if (remaining != 16'd0) begin
                  cnt_nxt   = hi_load;
                  state_nxt = HIGH;
               end else begin
                  completed = 1'b1;
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Done only when nothing is left queued after this cycle's pop and nothing is arriving.
   assign done_set = completed && !push_req && ((level - LW'(pop)) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         remaining <= 16'd0;
         cur_dir   <= 2'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         remaining <= remaining_nxt;
         cur_dir   <= cur_dir_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= data_in[17:0];
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push_ok) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg       <= 18'd0;
         overflow  <= 1'b0;
         done_pend <= 1'b0;
         total     <= 32'd0;
      end else begin
         if (we_any && (address == 6'h04)) begin
            cfg[7:0] <= data_in[7:0];
            if (data_write_n != 2'b00) cfg[15:8]  <= data_in[15:8];
            if (we_word)               cfg[17:16] <= data_in[17:16];
         end
         if (overflow_set)                overflow <= 1'b1;
         else if (clear_wr && data_in[1]) overflow <= 1'b0;
         if (done_set)                    done_pend <= 1'b1;
         else if (clear_wr && data_in[0]) done_pend <= 1'b0;
         if (total_inc) total <= total + 32'd1;
      end
   end

   always_comb begin
      data_out = 32'd0;
      case (address)
         6'h00:   data_out = {29'd0, level3};
         6'h04:   data_out = {14'd0, cfg};
         6'h08:   data_out = {24'd0, done_pend, overflow, busy, empty, full, level3};
         6'h0C:   data_out = {14'd0, cur_dir, remaining};
         6'h14:   data_out = total;
         default: data_out = 32'd0;
      endcase
   end

   assign busy           = state != IDLE;
   assign user_interrupt = done_pend & cfg[17];
   assign uo_out[3:0]    = (state == HIGH) ? (4'b0001 << cur_dir) : 4'b0000;
   assign uo_out[4]      = busy;
   assign uo_out[5]      = full;
   assign uo_out[6]      = user_interrupt;
   assign uo_out[7]      = 1'b0;
   assign data_ready     = 1'b1;
   assign dbg_state      = state;
   assign unused_inputs  = ^{ui_in, data_read_n, data_in[31:18]};
endmodule

// File: tb/tb_tqvp_spike_odom_encoder.sv
// Directed bench for the odometry spike encoder: cycle-exact checks on the spike lines
// plus a spike scoreboard fed when commands are queued.
`timescale 1ns/1ps
module tb_tqvp_spike_odom_encoder;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_NONE = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ui_in = 8'h5A;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'h3F;
   logic [31:0] data_in = 32'd0;
   logic [1:0]  data_write_n = SZ_NONE;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;
   logic [1:0]  dbg_state;

   int          n_total = 0;
   int          n_bad = 0;
   logic [11:0] exp_q[$];
   logic        sb_on = 1'b1;
   logic [7:0]  run_len = 8'd0;
   logic [3:0]  run_pat = 4'd0;
   logic [31:0] rd;
   logic [7:0]  t2_exp [8];
   logic [7:0]  t4_exp [4];

   tqvp_spike_odom_encoder #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
      .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
      .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
      address      = a;
      data_in      = d;
      data_write_n = sz;
      @(negedge clk);
      data_write_n = SZ_NONE;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = data_out;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      logic [31:0] st;
      n = 0;
      bus_read(6'h08, st);
      while ((st[4] == 1'b0 || st[5] == 1'b1) && n < max_cycles) begin
         @(negedge clk);
         bus_read(6'h08, st);
         n++;
      end
      check("drain_in_budget", 32'(n < max_cycles), 32'd1);
   endtask

   // scoreboard: each completed spike is checked as {high width, one-hot lines}
   always @(negedge clk) begin
      if (rst || !sb_on) begin
         run_len = 8'd0;
         run_pat = 4'd0;
      end else if (uo_out[3:0] != 4'd0) begin
         if (run_len == 8'd0) run_pat = uo_out[3:0];
         run_len = run_len + 8'd1;
      end else if (run_len != 8'd0) begin
         check("sb_spike_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("sb_spike", 32'({run_len, run_pat}), 32'(exp_q.pop_front()));
         run_len = 8'd0;
      end
   end

   initial begin
      t2_exp = '{8'h12, 8'h10, 8'h12, 8'h10, 8'h00, 8'h18, 8'h10, 8'h40};
      t4_exp = '{8'h00, 8'h14, 8'h10, 8'h00};

      // reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_uo", 32'(uo_out), 32'h0);
      check("rst_irq", 32'(user_interrupt), 32'h0);
      check("rst_ready", 32'(data_ready), 32'h1);
      check("rst_state", 32'(dbg_state), 32'h0);
      bus_read(6'h08, rd); check("rst_status", rd, 32'h10);
      bus_read(6'h04, rd); check("rst_config", rd, 32'h0);
      bus_read(6'h14, rd); check("rst_total", rd, 32'h0);
      bus_read(6'h18, rd); check("rst_unmapped", rd, 32'h0);

      // 1: HI=2 LO=3, three E spikes on a fixed timeline
      bus_write(6'h04, 32'h0001_0302, SZ_WORD);
      repeat (3) exp_q.push_back({8'd2, 4'b0001});
      bus_write(6'h00, 32'h0000_0003, SZ_WORD);
      for (int c = 1; c <= 17; c++) begin
         logic [4:0] e;
         e[3:0] = (c >= 2 && c <= 13 && ((c - 2) % 5) < 2) ? 4'b0001 : 4'b0000;
         e[4]   = (c >= 2 && c <= 16);
         check($sformatf("t1_uo_c%0d", c), 32'(uo_out[4:0]), 32'(e));
         if (c < 17) @(negedge clk);
      end
      bus_read(6'h08, rd); check("t1_status_done", rd, 32'h90);
      bus_read(6'h14, rd); check("t1_total", rd, 32'd3);
      check("t1_irq_masked", 32'(user_interrupt), 32'h0);
      bus_write(6'h10, 32'h1, SZ_WORD);
      bus_read(6'h08, rd); check("t1_status_clr", rd, 32'h10);

      // 2: N,N then S with one idle gap, irq enabled
      bus_write(6'h04, 32'h0003_0101, SZ_WORD);
      exp_q.push_back({8'd1, 4'b0010});
      exp_q.push_back({8'd1, 4'b0010});
      exp_q.push_back({8'd1, 4'b1000});
      bus_write(6'h00, 32'h0001_0002, SZ_WORD);
      bus_write(6'h00, 32'h0003_0001, SZ_WORD);
      for (int c = 2; c <= 9; c++) begin
         check($sformatf("t2_uo_c%0d", c), 32'(uo_out), 32'(t2_exp[c-2]));
         if (c < 9) @(negedge clk);
      end
      bus_write(6'h10, 32'h1, SZ_WORD);
      check("t2_irq_cleared", 32'(user_interrupt), 32'h0);
      check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

      // 3: disabled, overfill the FIFO, then drain it
      bus_write(6'h04, 32'h0000_0101, SZ_WORD);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({8'd1, 4'(4'b0001 << (i % 4))});
         bus_write(6'h00, (32'(i % 4) << 16) | 32'd1, SZ_WORD);
      end
      bus_read(6'h08, rd); check("t3_status_ovf", rd, 32'h4C);
      bus_read(6'h00, rd); check("t3_level", rd, 32'd4);
      check("t3_uo_full", 32'(uo_out), 32'h20);
      bus_write(6'h10, 32'h2, SZ_WORD);
      bus_read(6'h08, rd); check("t3_status_ovf_clr", rd, 32'h0C);
      bus_write(6'h04, 32'h0001_0101, SZ_WORD);
      wait_idle(100);
      check("t3_sb_drained", 32'(exp_q.size()), 32'd0);
      bus_read(6'h14, rd); check("t3_total", rd, 32'd10);
      bus_read(6'h08, rd); check("t3_status_done", rd, 32'h90);
      bus_write(6'h10, 32'h1, SZ_WORD);

      // 4: zero-count command is discarded, done only after the W spike
      exp_q.push_back({8'd1, 4'b0100});
      bus_write(6'h00, 32'h0000_0000, SZ_WORD);
      bus_write(6'h00, 32'h0002_0001, SZ_WORD);
      for (int c = 2; c <= 5; c++) begin
         check($sformatf("t4_uo_c%0d", c), 32'(uo_out), 32'(t4_exp[c-2]));
         bus_read(6'h08, rd);
         check($sformatf("t4_done_c%0d", c), 32'(rd[7]), 32'(c == 5));
         if (c < 5) @(negedge clk);
      end
      check("t4_sb_drained", 32'(exp_q.size()), 32'd0);
      bus_read(6'h14, rd); check("t4_total", rd, 32'd11);
      bus_write(6'h10, 32'h1, SZ_WORD);

      // 5: enable dropped mid-HIGH abandons the command
      sb_on = 1'b0;
      bus_write(6'h04, 32'h0001_0104, SZ_WORD);
      bus_write(6'h00, 32'h0000_000A, SZ_WORD);
      @(negedge clk);
      check("t5_high_c2", 32'(uo_out), 32'h11);
      @(negedge clk);
      bus_write(6'h04, 32'h0000_0104, SZ_WORD);
      check("t5_high_c4", 32'(uo_out), 32'h11);
      bus_read(6'h0C, rd); check("t5_remain_c4", rd, 32'h0000_000A);
      @(negedge clk);
      check("t5_uo_dropped", 32'(uo_out), 32'h0);
      check("t5_state", 32'(dbg_state), 32'h0);
      bus_read(6'h0C, rd); check("t5_remain", rd, 32'h0);
      bus_read(6'h08, rd); check("t5_status", rd, 32'h10);
      bus_read(6'h14, rd); check("t5_total", rd, 32'd11);

      // 6: reset during LOW
      bus_write(6'h04, 32'h0001_0401, SZ_WORD);
      bus_write(6'h00, 32'h0001_0002, SZ_WORD);
      repeat (3) @(negedge clk);
      check("t6_in_low", 32'(dbg_state), 32'h2);
      bus_read(6'h0C, rd); check("t6_remain_low", rd, 32'h0001_0001);
      bus_read(6'h14, rd); check("t6_total_low", rd, 32'd12);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_uo", 32'(uo_out), 32'h0);
      check("t6_state", 32'(dbg_state), 32'h0);
      bus_read(6'h08, rd); check("t6_status", rd, 32'h10);
      bus_read(6'h14, rd); check("t6_total", rd, 32'h0);
      bus_read(6'h04, rd); check("t6_config", rd, 32'h0);
      bus_read(6'h0C, rd); check("t6_remain", rd, 32'h0);
      @(negedge clk);
      check("t6_uo_after", 32'(uo_out), 32'h0);

      // 7: CONFIG byte lanes and non-word CMD writes
      bus_write(6'h04, 32'hFFFF_FFFF, SZ_BYTE);
      bus_read(6'h04, rd); check("t7_cfg_byte", rd, 32'h0000_00FF);
      bus_write(6'h04, 32'hFFFF_ABCD, SZ_HALF);
      bus_read(6'h04, rd); check("t7_cfg_half", rd, 32'h0000_ABCD);
      bus_write(6'h04, 32'hFFFE_0000, SZ_WORD);
      bus_read(6'h04, rd); check("t7_cfg_word", rd, 32'h0002_0000);
      bus_write(6'h00, 32'h0000_0001, SZ_BYTE);
      bus_write(6'h00, 32'h0000_0001, SZ_HALF);
      bus_read(6'h08, rd); check("t7_cmd_narrow_ignored", rd, 32'h10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
